// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters (ALU, memory load) and the
// register-file write port.
//   alu_*/mem_*   : valid/ready request channels carrying destination reg and data
//   reg_write/write_reg/write_data : registered register-file write port
// modport master : requester / register-file side
// modport slave  : arbiter side
interface regfile_wb_arbiter_if;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [REG_W-1:0]  mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              reg_write;
  logic [REG_W-1:0]  write_reg;
  logic [DATA_W-1:0] write_data;

  modport master (
    output alu_valid, alu_reg, alu_data,
    input  alu_ready,
    output mem_valid, mem_reg, mem_data,
    input  mem_ready,
    input  reg_write, write_reg, write_data
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    output alu_ready,
    input  mem_valid, mem_reg, mem_data,
    output mem_ready,
    output reg_write, write_reg, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU and memory-load write-back paths.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   wb_enable    : global grant enable
//   bus          : request channels (combinational ready) and registered write port
//   last_grant   : most recently granted requester (0 = ALU, 1 = MEM)
//   conflict_cnt : saturating count of enabled cycles with both requesters valid
module regfile_wb_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_enable,
  regfile_wb_arbiter_if.slave  bus,
  output logic                 last_grant,
  output logic [CNT_W-1:0]     conflict_cnt
);
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              both_valid_c;
  logic              grant_alu_c;
  logic              grant_mem_c;
  logic              grant_c;
  logic [REG_W-1:0]  win_reg_c;
  logic [DATA_W-1:0] win_data_c;

  logic              reg_write_q,  reg_write_nxt;
  logic [REG_W-1:0]  write_reg_q,  write_reg_nxt;
  logic [DATA_W-1:0] write_data_q, write_data_nxt;
  logic              last_grant_nxt;
  logic [CNT_W-1:0]  conflict_cnt_nxt;

  // Grant selection and next-state computation.
  always_comb begin
    both_valid_c     = bus.alu_valid && bus.mem_valid;
    grant_alu_c      = 1'b0;
    grant_mem_c      = 1'b0;
    reg_write_nxt    = 1'b0;
    write_reg_nxt    = write_reg_q;
    write_data_nxt   = write_data_q;
    last_grant_nxt   = last_grant;
    conflict_cnt_nxt = conflict_cnt;

    // Readys are forced low during reset so no handshake can complete.
    if (!reset && wb_enable) begin
      if (both_valid_c) begin
        // Tie: the requester that did not win last time goes next.
        grant_alu_c = last_grant;
        grant_mem_c = !last_grant;
      end else begin
        grant_alu_c = bus.alu_valid;
        grant_mem_c = bus.mem_valid;
      end
    end

    grant_c    = grant_alu_c || grant_mem_c;
    win_reg_c  = grant_mem_c ? bus.mem_reg  : bus.alu_reg;
    win_data_c = grant_mem_c ? bus.mem_data : bus.alu_data;

    if (grant_c) begin
      // r0 is hardwired: the transfer completes but no write is issued.
      reg_write_nxt  = (win_reg_c != REG_W'(0));
      write_reg_nxt  = win_reg_c;
      write_data_nxt = win_data_c;
      last_grant_nxt = grant_mem_c;
    end

    if (both_valid_c && wb_enable && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt_nxt = conflict_cnt + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      last_grant   <= 1'b1;
      conflict_cnt <= '0;
    end else begin
      reg_write_q  <= reg_write_nxt;
      write_reg_q  <= write_reg_nxt;
      write_data_q <= write_data_nxt;
      last_grant   <= last_grant_nxt;
      conflict_cnt <= conflict_cnt_nxt;
    end
  end

  assign bus.alu_ready  = grant_alu_c;
  assign bus.mem_ready  = grant_mem_c;
  assign bus.reg_write  = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus with literal expectations,
// plus a per-cycle comparison against a transaction-level model.
module tb_regfile_wb_arbiter;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             wb_enable;
  logic             last_grant;
  logic [CNT_W-1:0] conflict_cnt;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_enable    (wb_enable),
    .bus          (bus),
    .last_grant   (last_grant),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who wins this cycle, -1 none, 0 ALU, 1 MEM.
  function automatic int pick(input bit rst, input bit en, input bit av,
                              input bit mv, input bit last);
    if (rst || !en) return -1;
    if (av && mv)   return (last == 1'b1) ? 0 : 1;
    if (av)         return 0;
    if (mv)         return 1;
    return -1;
  endfunction

  bit       model_ok = 1'b0;
  bit       m_rw;
  int       m_reg;
  int       m_data;
  bit       m_last;
  int       m_cnt;
  int       m_win;

  // Compare outputs against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    m_win = pick(reset, wb_enable, bus.alu_valid, bus.mem_valid, m_last);
    if (model_ok) begin
      check("m_reg_write",  32'(bus.reg_write),  32'(m_rw));
      check("m_write_reg",  32'(bus.write_reg),  32'(m_reg));
      check("m_write_data", 32'(bus.write_data), 32'(m_data));
      check("m_last_grant", 32'(last_grant),     32'(m_last));
      check("m_conflict",   32'(conflict_cnt),   32'(m_cnt));
      check("m_alu_ready",  32'(bus.alu_ready),  32'(m_win == 0));
      check("m_mem_ready",  32'(bus.mem_ready),  32'(m_win == 1));
    end
    if (reset) begin
      m_rw = 0; m_reg = 0; m_data = 0; m_last = 1; m_cnt = 0;
      model_ok = 1'b1;
    end else begin
      if (wb_enable && bus.alu_valid && bus.mem_valid && m_cnt < CNT_MAX) m_cnt++;
      if (m_win < 0) begin
        m_rw = 0;
      end else begin
        m_reg  = (m_win == 0) ? int'(bus.alu_reg)  : int'(bus.mem_reg);
        m_data = (m_win == 0) ? int'(bus.alu_data) : int'(bus.mem_data);
        m_rw   = (m_reg != 0);
        m_last = (m_win == 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.mem_valid = 0;
  endtask

  bit prev_alu;

  initial begin
    reset = 1; wb_enable = 1;
    bus.alu_valid = 1; bus.alu_reg = 3'd1; bus.alu_data = 16'h1234;
    bus.mem_valid = 1; bus.mem_reg = 3'd2; bus.mem_data = 16'h5678;

    // Reset: readys low while reset is high, then clean outputs.
    step(); #1;
    check("rst_alu_ready", 32'(bus.alu_ready), 0);
    check("rst_mem_ready", 32'(bus.mem_ready), 0);
    step();
    check("rst_alu_ready2", 32'(bus.alu_ready), 0);
    reset = 0; idle();
    step();
    check("rst_reg_write",  32'(bus.reg_write),  0);
    check("rst_write_reg",  32'(bus.write_reg),  0);
    check("rst_write_data", 32'(bus.write_data), 0);
    check("rst_last_grant", 32'(last_grant),     1);
    check("rst_conflict",   32'(conflict_cnt),   0);

    // Single ALU write, one cycle latency.
    bus.alu_valid = 1; bus.alu_reg = 3'd3; bus.alu_data = 16'hBEEF;
    #1;
    check("alu_ready", 32'(bus.alu_ready), 1);
    check("alu_mem_ready", 32'(bus.mem_ready), 0);
    step(); idle();
    check("alu_reg_write",  32'(bus.reg_write),  1);
    check("alu_write_reg",  32'(bus.write_reg),  3);
    check("alu_write_data", 32'(bus.write_data), 32'hBEEF);
    check("alu_last_grant", 32'(last_grant),     0);
    step();
    check("alu_reg_write_off", 32'(bus.reg_write), 0);
    check("alu_write_reg_hold", 32'(bus.write_reg), 3);

    // Contention from reset: ALU first, then MEM.
    reset = 1; step(); reset = 0;
    bus.alu_valid = 1; bus.alu_reg = 3'd1; bus.alu_data = 16'h0011;
    bus.mem_valid = 1; bus.mem_reg = 3'd2; bus.mem_data = 16'h0022;
    #1;
    check("con_alu_first", 32'(bus.alu_ready), 1);
    check("con_mem_wait",  32'(bus.mem_ready), 0);
    step(); bus.alu_valid = 0; #1;
    check("con_rw1",   32'(bus.reg_write),  1);
    check("con_reg1",  32'(bus.write_reg),  1);
    check("con_data1", 32'(bus.write_data), 32'h0011);
    check("con_cnt1",  32'(conflict_cnt),   1);
    check("con_mem_ready", 32'(bus.mem_ready), 1);
    step(); bus.mem_valid = 0;
    check("con_rw2",   32'(bus.reg_write),  1);
    check("con_reg2",  32'(bus.write_reg),  2);
    check("con_data2", 32'(bus.write_data), 32'h0022);
    check("con_cnt2",  32'(conflict_cnt),   1);
    step();
    check("con_rw_off", 32'(bus.reg_write), 0);

    // Register 0: handshake completes, no write enable.
    bus.mem_valid = 1; bus.mem_reg = 3'd0; bus.mem_data = 16'hFFFF;
    #1;
    check("r0_mem_ready", 32'(bus.mem_ready), 1);
    step(); idle();
    check("r0_reg_write",  32'(bus.reg_write),  0);
    check("r0_write_reg",  32'(bus.write_reg),  0);
    check("r0_write_data", 32'(bus.write_data), 32'hFFFF);
    check("r0_last_grant", 32'(last_grant),     1);

    // Enable gating: nothing granted, counter frozen.
    wb_enable = 0;
    bus.alu_valid = 1; bus.alu_reg = 3'd5; bus.alu_data = 16'h5555;
    bus.mem_valid = 1; bus.mem_reg = 3'd6; bus.mem_data = 16'h6666;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("gate_alu_ready", 32'(bus.alu_ready), 0);
      check("gate_mem_ready", 32'(bus.mem_ready), 0);
      step();
      check("gate_reg_write", 32'(bus.reg_write), 0);
    end
    check("gate_cnt", 32'(conflict_cnt), 1);
    check("gate_last", 32'(last_grant), 1);
    wb_enable = 1; #1;
    check("ungate_alu_first", 32'(bus.alu_ready), 1);
    step();
    check("ungate_mem_next", 32'(bus.mem_ready), 1);
    check("ungate_data", 32'(bus.write_data), 32'h5555);
    check("ungate_cnt", 32'(conflict_cnt), 2);
    step();
    check("ungate_alu_again", 32'(bus.alu_ready), 1);
    check("ungate_data2", 32'(bus.write_data), 32'h6666);
    check("ungate_cnt2", 32'(conflict_cnt), 3);

    // Saturation: 300 contended cycles with strict alternation.
    prev_alu = bus.alu_ready;
    for (int i = 0; i < 300; i++) begin
      step();
      check("sat_alternate", 32'(bus.alu_ready), 32'(!prev_alu));
      check("sat_one_ready", 32'(bus.alu_ready ^ bus.mem_ready), 1);
      prev_alu = bus.alu_ready;
    end
    check("sat_cnt", 32'(conflict_cnt), 255);
    step(); step();
    check("sat_cnt_hold", 32'(conflict_cnt), 255);

    // Reset mid-operation: readys forced low, write discarded.
    reset = 1; bus.mem_valid = 0; #1;
    check("mid_rst_alu_ready", 32'(bus.alu_ready), 0);
    step(); reset = 0; idle();
    check("mid_rst_reg_write", 32'(bus.reg_write), 0);
    check("mid_rst_cnt",       32'(conflict_cnt),  0);
    check("mid_rst_last",      32'(last_grant),    1);

    // Same destination on a tie: both writes land, MEM last.
    bus.alu_valid = 1; bus.alu_reg = 3'd4; bus.alu_data = 16'hAAAA;
    bus.mem_valid = 1; bus.mem_reg = 3'd4; bus.mem_data = 16'hBBBB;
    step(); bus.alu_valid = 0;
    check("same_rw1",   32'(bus.reg_write),  1);
    check("same_reg1",  32'(bus.write_reg),  4);
    check("same_data1", 32'(bus.write_data), 32'hAAAA);
    step(); bus.mem_valid = 0;
    check("same_rw2",   32'(bus.reg_write),  1);
    check("same_reg2",  32'(bus.write_reg),  4);
    check("same_data2", 32'(bus.write_data), 32'hBBBB);
    step();
    check("same_rw_off", 32'(bus.reg_write), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 8×16-bit register file's single write port. It shares the port between two requesters, the ALU write-back path and the memory-load write-back path, using valid/ready handshakes and round-robin arbitration on contention. It drives registered `reg_write`/`write_reg`/`write_data` into the register file. It also exposes the in-flight write so hazard/forwarding logic can observe it.

## Interface
Parameters:
- `CNT_W`, default 8: width of the contention counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `wb_enable`  in  1  global grant enable; when low, no request is granted.
- `alu_valid`  in  1  ALU write-back request.
- `alu_reg`  in  3  ALU destination register.
- `alu_data`  in  16  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`  in  1  load write-back request.
- `mem_reg`  in  3  load destination register.
- `mem_data`  in  16  load data.
- `mem_ready`  out  1  load request accepted this cycle.
- `reg_write`  out  1  register-file write enable (registered).
- `write_reg`  out  3  register-file write address (registered).
- `write_data`  out  16  register-file write data (registered).
- `last_grant`  out  1  0 = ALU, 1 = MEM; the requester most recently granted.
- `conflict_cnt`  out  CNT_W  saturating count of contended cycles.

## Operation
- Handshake: a transfer occurs on a cycle where `X_valid && X_ready`. A requester holds valid, reg and data stable until ready. Valid does not depend on ready.
- Ready is combinational from the current valid inputs, `wb_enable` and `last_grant`. At most one ready is high per cycle.
- Grant rules, evaluated each cycle with `wb_enable` high:
  - Only ALU valid: grant ALU.
  - Only MEM valid: grant MEM.
  - Both valid: grant the requester that is not `last_grant`.
  - Neither valid: no grant; `last_grant` holds.
- `wb_enable` low: both readys low, `last_grant` holds, no output write is produced.
- On a grant, the output stage captures the winner's reg and data at the clock edge. `last_grant` updates to the winner at the same edge.
- Writes to register 0:
  - The handshake completes normally, so the requester is released.
  - Output `reg_write` stays 0 for that transfer.
  - `write_reg`/`write_data` still capture the values.
  - `last_grant` updates as for any grant.
- Contention counter:
  - `conflict_cnt` increments on every cycle with `alu_valid && mem_valid && wb_enable`.
  - It saturates at all-ones and never wraps.
- The output stage has no back-pressure: the register file accepts a write every cycle.

## Timing
- Reset values: `reg_write`=0, `write_reg`=0, `write_data`=0, `last_grant`=1, `conflict_cnt`=0. Because `last_grant` resets to 1, the first tie after reset goes to the ALU.
- Latency: handshake at cycle N drives `reg_write`=1 with that reg/data during cycle N+1. The register-file write lands at the edge ending N+1.
- Throughput: one write per cycle. Back-to-back grants produce `reg_write` high on consecutive cycles.
- A cycle without a grant drives `reg_write`=0 on the next cycle. `write_reg`/`write_data` hold their previous values.
- Both requesters continuously valid: grants alternate ALU, MEM, ALU, ... every cycle.
- Reset asserted mid-operation:
  - Any captured but not-yet-driven write is discarded; `reg_write` is 0 the cycle after reset.
  - Readys are forced low while reset is high.
  - Requesters must re-present their requests afterwards.
- Both requesters targeting the same register on a tie: both writes occur, in grant order, in consecutive cycles. The later grant's data is the final value.

## Test plan
- Reset check: assert reset 2 cycles then release -> all outputs 0 except `last_grant`=1; `alu_ready`/`mem_ready` stay 0 during reset.
- Single ALU write: `alu_valid`=1, `alu_reg`=3, `alu_data`=16'hBEEF for 1 cycle -> `alu_ready`=1 that cycle. Next cycle `reg_write`=1, `write_reg`=3, `write_data`=16'hBEEF; the cycle after, `reg_write`=0.
- Contention: both valid with ALU (r1, 16'h0011) and MEM (r2, 16'h0022), held until accepted, starting from reset -> ALU granted first, then MEM. Outputs are r1/0011 then r2/0022 on consecutive cycles; `conflict_cnt`=1.
- Register 0 drop: `mem_valid`, `mem_reg`=0, `mem_data`=16'hFFFF -> `mem_ready`=1; next cycle `reg_write`=0, `write_reg`=0; `last_grant`=1.
- Enable gating: both valid with `wb_enable`=0 for 4 cycles, then 1 -> no readys and `reg_write`=0 during gating; `conflict_cnt` unchanged. After enable, alternation resumes from the held `last_grant`.
- Saturation: CNT_W=8, both valid and enabled for 300 cycles -> `conflict_cnt`=255 and stays 255; grants alternate every cycle throughout.
